top_level_proc: RTL and testbench
=================================

// Module: top_level_proc
// PURPOSE
//   Self-starting pattern-count engine ("program 3"). After reset is released it
//   counts occurrences of a 5-bit pattern in a 32-byte message held in its data
//   memory, writes three counts back to memory, then raises done.
//   Top of the design; its only pins are clk, reset and done. Stimulus and results
//   go through the data memory instance dm1, array core.
// PARAMETERS
//   MEM_DEPTH  256  data memory depth in bytes (dm1.core[0:MEM_DEPTH-1])
//   MSG_BYTES  32   message length in bytes (mem[0..31])
//   PAT_ADDR   32   byte address of the pattern
//   RES_ADDR   33   base address of the three result bytes (33, 34, 35)
// PORTS
//   clk    input  1  rising-edge clock
//   reset  input  1  asynchronous, active-low reset (name kept from codebase)
//   done   output 1  high = results written; held until next reset
// BEHAVIOUR
// - Memory: instance dm1, array core[MEM_DEPTH] of 8 bits.
//   - Combinational read; synchronous write on posedge clk.
//   - Not cleared by reset; the bench preloads it by hierarchical access.
// - Inputs:
//   - pattern P = mem[32][4:0]; bits [7:5] ignored.
//   - message bytes mem[0..31]; mem[0] is the most significant byte.
//     The 256-bit string S = {mem[0], mem[1], ..., mem[31]}.
// - Outputs:
//   - mem[33] = CTB: count over j=0..31 and k=0..3 of matches P == mem[j][k+4:k].
//     Range 0..128.
//   - mem[34] = CTO: number of bytes j where any of the 4 in-byte windows matches.
//     Range 0..32.
//   - mem[35] = CTS: number of 5-bit windows of S, at any alignment, equal to P.
//     There are 252 windows (S[255:251] down to S[4:0]). Range 0..252, fits 8 bits.
//     CTS = CTB + matches in the 4 boundary windows of {mem[j-1], mem[j]} (j=1..31):
//     bits [11:7], [10:6], [9:5] and [8:4] of that 16-bit concatenation.
// - Reset (reset==0, async):
//   - FSM goes to LOAD; done=0.
//   - counters, byte index and previous-byte register cleared; no memory writes.
// - FSM, one state step per posedge after reset goes high:
//   - LOAD: latch P from mem[32]; idx=0. -> SCAN
//   - SCAN: read mem[idx].
//     - CTB += in-byte matches (0..4); CTO += 1 if any in-byte match.
//     - if idx>0, CTS += boundary matches against prev byte.
//     - prev = mem[idx]; idx++. After idx==31 -> WR0.
//   - WR0: mem[33] = CTB. -> WR1
//   - WR1: mem[34] = CTO. -> WR2
//   - WR2: mem[35] = CTB + boundary total (= CTS). -> DONE
//   - DONE: done=1, no further writes; stays here until reset.
// - Latency: done rises on the 36th rising edge after reset deasserts
//   (1 LOAD + 32 SCAN + 3 WR).
// - Counter widths: 8 bits; values never exceed 252, so no wrap logic is needed.
// - Reset mid-operation: abort immediately and drop done.
//   - Result bytes already written stay as written.
//   - After release, a full rerun from LOAD with current memory contents.
// - Only mem[33..35] are ever written.
// TESTING
// - mem[0..31]=0x00, mem[32]=0x00 -> mem[33]=128, mem[34]=32, mem[35]=252; done by edge 36.
// - mem[0..31]=0x55, mem[32]=0x15 -> mem[33]=64, mem[34]=32, mem[35]=126.
// - mem[0..31]=0x00, mem[32]=0x01 -> mem[33]=0, mem[34]=0, mem[35]=0.
// - mem[0]=0x07, mem[1]=0xC0, mem[2..31]=0, P=0x1F -> mem[33]=0, mem[34]=0, mem[35]=1
//   (boundary-only match).
// - Random mem[0..31] and P -> all three counts equal a software model of the
//   definitions above.
// - Pull reset low 10 cycles into SCAN -> done=0 immediately; after release the
//   rerun yields the same correct results.

Source files
------------

// File: rtl/top_level_proc.sv
// top_level_proc: self-starting 5-bit pattern counter over a 32-byte message held in data memory
module data_mem #(
    parameter int DEPTH = 256,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] core [DEPTH];
    always_ff @(posedge clk)
        if (we) core[waddr] <= wdata;
    assign rdata = core[raddr];
endmodule

module top_level_proc #(
    parameter int MEM_DEPTH = 256,
    parameter int MSG_BYTES = 32,
    parameter int PAT_ADDR = 32,
    parameter int RES_ADDR = 33
) (
    input  logic clk,
    input  logic reset,
    output logic done
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int IW = $clog2(MSG_BYTES);
    typedef enum logic [2:0] {LOAD, SCAN, WR0, WR1, WR2, DONE} state_t;
    state_t state;
    logic [IW-1:0] idx;
    logic [4:0] pat;
    logic [7:0] prev, ctb, cto, bnd, rdata, wdata;
    logic [AW-1:0] raddr, waddr;
    logic we;
    logic [2:0] in_hits, bnd_hits;
    logic [15:0] pair;
    data_mem #(.DEPTH(MEM_DEPTH)) dm1 (
        .clk(clk), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata)
    );
    always_comb begin
        raddr = state == LOAD ? AW'(PAT_ADDR) : AW'(idx);
        we = state inside {WR0, WR1, WR2};
        waddr = AW'(RES_ADDR) + (state == WR1 ? AW'(1) : state == WR2 ? AW'(2) : AW'(0));
        wdata = state == WR0 ? ctb : state == WR1 ? cto : ctb + bnd;
        pair = {prev, rdata};
        in_hits = '0;
        bnd_hits = '0;
        // boundary windows are the four straddling prev/current: pair[8:4]..pair[11:7]
        for (int k = 0; k < 4; k++) begin
            in_hits = in_hits + {2'b0, rdata[k +: 5] == pat};
            bnd_hits = bnd_hits + {2'b0, pair[k + 4 +: 5] == pat};
        end
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= LOAD;
            done <= 1'b0;
            idx <= '0;
            pat <= '0;
            prev <= '0;
            ctb <= '0;
            cto <= '0;
            bnd <= '0;
        end else
            case (state)
                LOAD: begin
                    pat <= rdata[4:0];
                    idx <= '0;
                    state <= SCAN;
                end
                SCAN: begin
                    ctb <= ctb + {5'b0, in_hits};
                    cto <= cto + {7'b0, in_hits != 3'd0};
                    if (idx != '0) bnd <= bnd + {5'b0, bnd_hits};
                    prev <= rdata;
                    idx <= idx + 1'b1;
                    if (idx == IW'(MSG_BYTES - 1)) state <= WR0;
                end
                WR0: state <= WR1;
                WR1: state <= WR2;
                WR2: begin
                    state <= DONE;
                    done <= 1'b1;
                end
                default: done <= 1'b1;
            endcase
endmodule

// File: tb/tb_top_level_proc.sv
// tb_top_level_proc: randomized and directed checks of the pattern-count engine against a string-level model
module tb_top_level_proc;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic done;
    int checks = 0;
    int failures = 0;
    logic [7:0] msg [32];
    logic [7:0] pat;

    top_level_proc dut (.clk(clk), .reset(reset), .done(done));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Counts straight from the definitions: per-byte windows and all 252 windows of the 256-bit string
    function automatic void model(output int ctb, output int cto, output int cts);
        logic [255:0] s;
        logic [4:0] p;
        int hits;
        p = pat[4:0];
        ctb = 0;
        cto = 0;
        cts = 0;
        for (int j = 0; j < 32; j++) begin
            s[255 - 8*j -: 8] = msg[j];
            hits = 0;
            for (int k = 0; k < 4; k++) if (msg[j][k +: 5] == p) hits++;
            ctb += hits;
            if (hits > 0) cto++;
        end
        for (int i = 0; i < 252; i++) if (s[i +: 5] == p) cts++;
    endfunction

    task automatic enter_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check({tag, ".done_drop"}, int'(done), 0);
    endtask

    task automatic preload;
        for (int j = 0; j < 32; j++) dut.dm1.core[j] = msg[j];
        dut.dm1.core[32] = pat;
        for (int j = 33; j < 36; j++) dut.dm1.core[j] = 8'hEE;
        dut.dm1.core[36] = 8'h5A;
    endtask

    task automatic run_to_done(input string tag);
        int ctb, cto, cts;
        int e = 0;
        model(ctb, cto, cts);
        @(negedge clk);
        reset = 1'b1;
        while (!done && e < 60) begin
            @(posedge clk);
            #1 e++;
        end
        check({tag, ".latency"}, e, 36);
        check({tag, ".ctb"}, int'(dut.dm1.core[33]), ctb);
        check({tag, ".cto"}, int'(dut.dm1.core[34]), cto);
        check({tag, ".cts"}, int'(dut.dm1.core[35]), cts);
        check({tag, ".pat_kept"}, int'(dut.dm1.core[32]), int'(pat));
        check({tag, ".guard"}, int'(dut.dm1.core[36]), 8'h5A);
        repeat (3) @(posedge clk);
        #1 check({tag, ".done_hold"}, int'(done), 1);
    endtask

    task automatic fill(input logic [7:0] b, input logic [7:0] p);
        for (int j = 0; j < 32; j++) msg[j] = b;
        pat = p;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 check("reset.done", int'(done), 0);
        fill(8'h00, 8'h00);
        preload();
        run_to_done("zeros_p00");
        enter_reset("r1");
        fill(8'h55, 8'h15);
        preload();
        run_to_done("x55_p15");
        enter_reset("r2");
        fill(8'h00, 8'h01);
        preload();
        run_to_done("zeros_p01");
        enter_reset("r3");
        fill(8'h00, 8'h1F);
        msg[0] = 8'h07;
        msg[1] = 8'hC0;
        preload();
        run_to_done("boundary");
        for (int n = 0; n < 8; n++) begin
            enter_reset("rr");
            for (int j = 0; j < 32; j++)
                msg[j] = (n % 2 == 1 && $urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            pat = 8'($urandom);
            if (n % 2 == 1) pat[4:0] = 5'h1F;
            preload();
            run_to_done($sformatf("rand%0d", n));
        end
        enter_reset("rm");
        for (int j = 0; j < 32; j++) msg[j] = 8'($urandom);
        pat = 8'($urandom);
        preload();
        @(negedge clk);
        reset = 1'b1;
        repeat (11) @(posedge clk);
        #2 reset = 1'b0;
        #1 check("midscan.done", int'(done), 0);
        check("midscan.nowrite", int'(dut.dm1.core[33]), 8'hEE);
        repeat (3) @(negedge clk);
        run_to_done("rerun");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
